// File: rtl/mem_seq_pkg.sv
// Shared phase map, E/Q windows and rate-mode encoding for mem_slot_sequencer.
package mem_seq_pkg;

  typedef enum logic {
    MODE_NORMAL = 1'b0,
    MODE_FAST   = 1'b1
  } mode_e;

  // Normal rate: 16 phases per E cycle
  localparam logic [3:0] PH_VID_ADDR = 4'd2;
  localparam logic [3:0] PH_VID_CAP  = 4'd4;
  localparam logic [3:0] PH_CPU_ADDR = 4'd10;
  localparam logic [3:0] PH_CPU_END  = 4'd15;
  localparam logic [3:0] PH_LAST     = 4'd15;
  localparam logic [3:0] Q_LO        = 4'd4;
  localparam logic [3:0] Q_HI        = 4'd11;
  localparam logic [3:0] E_LO        = 4'd8;
  localparam logic [3:0] E_HI        = 4'd15;

  // Fast rate: 8 phases per E cycle, CPU only
  localparam logic [3:0] PH_F_CPU_ADDR = 4'd2;
  localparam logic [3:0] PH_F_CPU_END  = 4'd7;
  localparam logic [3:0] PH_F_LAST     = 4'd7;
  localparam logic [3:0] F_Q_LO        = 4'd2;
  localparam logic [3:0] F_Q_HI        = 4'd5;
  localparam logic [3:0] F_E_LO        = 4'd4;
  localparam logic [3:0] F_E_HI        = 4'd7;

  function automatic logic in_window(input logic [3:0] ph, input logic [3:0] lo,
                                     input logic [3:0] hi);
    return (ph >= lo) && (ph <= hi);
  endfunction

endpackage

// File: rtl/mem_slot_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first requester above ptr_i (mod NUM_VID).
module rr_arbiter #(
  parameter int NUM_VID = 2,
  parameter int IDX_W   = (NUM_VID > 1) ? $clog2(NUM_VID) : 1
) (
  input  logic [NUM_VID-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);

  always_comb begin
    gnt_idx_o = ptr_i;
    gnt_vld_o = 1'b0;
    for (int off = 1; off <= NUM_VID; off++) begin
      for (int i = 0; i < NUM_VID; i++) begin
        if (!gnt_vld_o && req_i[i] && (((int'(ptr_i) + off) % NUM_VID) == i)) begin
          gnt_vld_o = 1'b1;
          gnt_idx_o = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mem_slot_sequencer.sv
// Tick divider, 6809E E/Q generator and CPU/video RAM slot interleaver; fixed capture points.
// Optional MEM_SEQ_WRITE_PROTECT_EN blocks CPU writes at or above WP_BASE and flags them on wp_hit.
module mem_slot_sequencer
  import mem_seq_pkg::*;
#(
  parameter int                DIV     = 4,
  parameter int                ADDR_W  = 16,
  parameter int                DATA_W  = 8,
  parameter int                NUM_VID = 2,
  parameter logic [ADDR_W-1:0] WP_BASE = 16'h8000
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      tick,
  input  logic                      fast,
  output logic                      e,
  output logic                      q,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic                      cpu_we,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic [DATA_W-1:0]         cpu_rdata,
  input  logic [NUM_VID-1:0]        vid_req,
  input  logic [NUM_VID*ADDR_W-1:0] vid_addr,
  output logic [NUM_VID-1:0]        vid_ack,
  output logic [DATA_W-1:0]         vid_data,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic                      ram_we,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata,
  output logic                      wp_hit
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NUM_VID > 1) ? $clog2(NUM_VID) : 1;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         ph_q, ph_d, ph_next;
  mode_e              mode_q, mode_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, gnt_idx_q, gnt_idx_d, arb_idx;
  logic               gnt_vld_q, gnt_vld_d, arb_vld;
  logic               cpu_we_q, cpu_we_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d, vid_sel_addr;
  logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]  vid_data_q, vid_data_d;
  logic [NUM_VID-1:0] vid_ack_q, vid_ack_d;
  logic               tick_w, is_fast, wrap, wr_slot;
  logic               at_vid_addr, at_vid_cap, at_cpu_addr, at_cpu_end;

  assign tick_w  = (div_q == DIV_W'(DIV - 1));
  assign is_fast = (mode_q == MODE_FAST);
  assign ph_next = ph_q + 4'd1;
  assign wrap    = tick_w && (ph_q == (is_fast ? PH_F_LAST : PH_LAST));

  // at_* flags: the current tick moves ph into the named phase
  assign at_vid_addr = tick_w && !is_fast && (ph_next == PH_VID_ADDR);
  assign at_vid_cap  = tick_w && !is_fast && (ph_next == PH_VID_CAP);
  assign at_cpu_addr = tick_w && (ph_next == (is_fast ? PH_F_CPU_ADDR : PH_CPU_ADDR));
  assign at_cpu_end  = tick_w && (ph_next == (is_fast ? PH_F_CPU_END : PH_CPU_END));
  assign wr_slot     = at_cpu_end && cpu_we_q;

  rr_arbiter #(
    .NUM_VID (NUM_VID),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i     (vid_req),
    .ptr_i     (ptr_q),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  always_comb begin
    vid_sel_addr = '0;
    for (int i = 0; i < NUM_VID; i++) begin
      if (arb_idx == IDX_W'(i)) vid_sel_addr = vid_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    div_d       = tick_w ? '0 : div_q + 1'b1;
    ph_d        = ph_q;
    mode_d      = mode_q;
    ptr_d       = ptr_q;
    gnt_vld_d   = gnt_vld_q;
    gnt_idx_d   = gnt_idx_q;
    cpu_we_d    = cpu_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_data_d  = vid_data_q;
    vid_ack_d   = '0;

    if (tick_w) ph_d = wrap ? 4'd0 : ph_next;
    // Rate changes only at the wrap so an E period is never cut short
    if (wrap) mode_d = fast ? MODE_FAST : MODE_NORMAL;

    if (at_vid_addr) begin
      gnt_vld_d = arb_vld;
      if (arb_vld) begin
        ptr_d      = arb_idx;
        gnt_idx_d  = arb_idx;
        ram_addr_d = vid_sel_addr;
      end
    end

    if (at_vid_cap && gnt_vld_q) begin
      vid_data_d = ram_rdata;
      gnt_vld_d  = 1'b0;
      for (int i = 0; i < NUM_VID; i++) begin
        vid_ack_d[i] = (gnt_idx_q == IDX_W'(i));
      end
    end

    if (at_cpu_addr) begin
      ram_addr_d  = cpu_addr;
      ram_wdata_d = cpu_wdata;
      cpu_we_d    = cpu_we;
    end

    if (at_cpu_end) begin
      if (!cpu_we_q) cpu_rdata_d = ram_rdata;
      cpu_we_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q       <= '0;
      ph_q        <= 4'd0;
      mode_q      <= MODE_NORMAL;
      ptr_q       <= IDX_W'(NUM_VID - 1);
      gnt_vld_q   <= 1'b0;
      gnt_idx_q   <= '0;
      cpu_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_rdata_q <= '0;
      vid_data_q  <= '0;
      vid_ack_q   <= '0;
    end else begin
      div_q       <= div_d;
      ph_q        <= ph_d;
      mode_q      <= mode_d;
      ptr_q       <= ptr_d;
      gnt_vld_q   <= gnt_vld_d;
      gnt_idx_q   <= gnt_idx_d;
      cpu_we_q    <= cpu_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_data_q  <= vid_data_d;
      vid_ack_q   <= vid_ack_d;
    end
  end

`ifdef MEM_SEQ_WRITE_PROTECT_EN
  logic wp_blk;
  // ram_addr_q still holds the CPU address from the address phase
  assign wp_blk = (ram_addr_q >= WP_BASE);
  assign ram_we = wr_slot && !wp_blk;
  assign wp_hit = wr_slot && wp_blk;
`else
  logic wp_base_unused;
  assign wp_base_unused = ^WP_BASE;
  assign ram_we = wr_slot;
  assign wp_hit = 1'b0;
`endif

  assign tick      = tick_w;
  assign q         = is_fast ? in_window(ph_q, F_Q_LO, F_Q_HI) : in_window(ph_q, Q_LO, Q_HI);
  assign e         = is_fast ? in_window(ph_q, F_E_LO, F_E_HI) : in_window(ph_q, E_LO, E_HI);
  assign cpu_rdata = cpu_rdata_q;
  assign vid_ack   = vid_ack_q;
  assign vid_data  = vid_data_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_slot_sequencer.sv
// Self-checking bench for mem_slot_sequencer with a synchronous RAM and a phase-level reference model.
`timescale 1ns/1ps
module tb_mem_slot_sequencer;

  localparam int          DIV = 4;
  localparam int          AW  = 16;
  localparam int          DW  = 8;
  localparam int          NV  = 2;
  localparam logic [15:0] WPB = 16'h8000;
`ifdef MEM_SEQ_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           tick, e, q, ram_we, wp_hit;
  logic           fast = 1'b0;
  logic [AW-1:0]  cpu_addr = '0;
  logic           cpu_we = 1'b0;
  logic [DW-1:0]  cpu_wdata = '0;
  logic [DW-1:0]  cpu_rdata, vid_data, ram_wdata;
  logic [DW-1:0]  ram_rdata = '0;
  logic [NV-1:0]  vid_req = '0;
  logic [NV*AW-1:0] vid_addr = '0;
  logic [NV-1:0]  vid_ack;
  logic [AW-1:0]  ram_addr;

  always #5 clk = ~clk;

  mem_slot_sequencer #(
    .DIV(DIV), .ADDR_W(AW), .DATA_W(DW), .NUM_VID(NV), .WP_BASE(WPB)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .fast(fast), .e(e), .q(q),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .wp_hit(wp_hit)
  );

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37) + (a >> 8) + 17);
  endfunction

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: phase counter per the E-cycle rules, events keyed on the phase being entered
  int         mk, mph, mptr, pidx;
  bit         mfast, pv, mcwe, wrapped;
  logic [15:0] mcaddr, paddr, m_addr;
  logic [7:0]  mcwd, m_wdata, m_vdata, m_rdata;
  logic [NV-1:0] m_ack;

  task automatic model_reset();
    mk = 0; mph = 0; mfast = 1'b0; mptr = NV - 1; pidx = 0; pv = 1'b0; mcwe = 1'b0;
    mcaddr = '0; paddr = '0; m_addr = '0; mcwd = '0; m_wdata = '0;
    m_vdata = '0; m_rdata = '0; m_ack = '0;
  endtask

  task automatic check_outputs();
    bit tk, bnd, prot, xe, xq;
    int endp;
    tk   = (mk == DIV - 1);
    endp = mfast ? 7 : 15;
    bnd  = tk && (mph + 1 == endp) && mcwe;
    prot = WP_EN && (mcaddr >= WPB);
    xe   = mfast ? (mph >= 4) : (mph >= 8);
    xq   = mfast ? (mph >= 2 && mph <= 5) : (mph >= 4 && mph <= 11);
    chk("tick", tick, tk);
    chk("e", e, xe);
    chk("q", q, xq);
    chk("ram_addr", ram_addr, m_addr);
    chk("ram_wdata", ram_wdata, m_wdata);
    chk("ram_we", ram_we, bnd && !prot);
    chk("wp_hit", wp_hit, bnd && prot);
    chk("cpu_rdata", cpu_rdata, m_rdata);
    chk("vid_ack", vid_ack, m_ack);
    chk("vid_data", vid_data, m_vdata);
  endtask

  task automatic step();
    bit f_in, we_in, tk;
    logic [15:0] ca_in;
    logic [7:0]  cd_in;
    logic [NV-1:0] rq_in;
    logic [NV*AW-1:0] va_in;
    int last, nph, c;
    f_in = fast; we_in = cpu_we; ca_in = cpu_addr; cd_in = cpu_wdata;
    rq_in = vid_req; va_in = vid_addr;
    tk = (mk == DIV - 1);
    last = mfast ? 7 : 15;
    @(posedge clk);
    #1;
    cyc++;
    m_ack = '0;
    wrapped = 1'b0;
    if (!reset) begin
      model_reset();
    end else begin
      if (tk) begin
        nph = (mph == last) ? 0 : mph + 1;
        if (mph == last) begin
          mfast = f_in;
          wrapped = 1'b1;
        end
        mph = nph;
        if (!mfast && nph == 2) begin
          pv = 1'b0;
          for (int j = 1; j <= NV; j++) begin
            c = (mptr + j) % NV;
            if (!pv && rq_in[c]) begin
              pv = 1'b1; pidx = c; paddr = va_in[c*AW +: AW];
            end
          end
          if (pv) begin
            mptr = pidx; m_addr = paddr;
          end
        end
        if (!mfast && nph == 4 && pv) begin
          m_vdata = ref_mem[paddr]; m_ack[pidx] = 1'b1; pv = 1'b0;
        end
        if (nph == (mfast ? 2 : 10)) begin
          mcwe = we_in; mcaddr = ca_in; mcwd = cd_in; m_addr = ca_in; m_wdata = cd_in;
        end
        if (nph == (mfast ? 7 : 15)) begin
          if (!mcwe) m_rdata = ref_mem[mcaddr];
          else if (!(WP_EN && mcaddr >= WPB)) ref_mem[mcaddr] = mcwd;
        end
      end
      mk = (mk + 1) % DIV;
    end
    check_outputs();
  endtask

  int we_cnt, wp_cnt, ack_cnt, we_ph;

  task automatic run_cycle();
    bit done;
    done = 1'b0; we_cnt = 0; wp_cnt = 0; ack_cnt = 0; we_ph = -1;
    for (int i = 0; i < 100 && !done; i++) begin
      step();
      if (ram_we) begin we_cnt++; we_ph = mph; end
      if (wp_hit) wp_cnt++;
      if (vid_ack != '0) ack_cnt++;
      done = wrapped;
    end
    if (!done) chk("cycle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tick"}, tick, 1'b0);
    chk({tag, "_e"}, e, 1'b0);
    chk({tag, "_q"}, q, 1'b0);
    chk({tag, "_ram_we"}, ram_we, 1'b0);
    chk({tag, "_ram_addr"}, ram_addr, 16'h0);
    chk({tag, "_ram_wdata"}, ram_wdata, 8'h0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 8'h0);
    chk({tag, "_vid_ack"}, vid_ack, 2'b00);
    chk({tag, "_vid_data"}, vid_data, 8'h0);
    chk({tag, "_wp_hit"}, wp_hit, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_all_zero("rst");
    model_reset();
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic step_until_ph(input int p);
    for (int i = 0; i < 80 && mph != p; i++) step();
    if (mph != p) chk("ph_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } cpu_vec_t;

  cpu_vec_t vecs [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int qr, er1, er2, ntk, nacks, addr_t, r1, r2, r3, ack_seen;
    bit pq, pe, found;
    logic [15:0] prev_addr, ack_addr;

    for (int i = 0; i < 65536; i++) begin
      mem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    model_reset();
    repeat (3) step();
    check_all_zero("init");
    reset = 1'b1;

    // Tick period, q/e timing from a fresh reset
    qr = -1; er1 = -1; er2 = -1; ntk = 0; pq = q; pe = e;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (i <= 64 && tick) ntk++;
      if (q && !pq && qr < 0) qr = i;
      if (e && !pe) begin
        if (er1 < 0) er1 = i; else if (er2 < 0) er2 = i;
      end
      pq = q; pe = e;
    end
    chk("ticks_in_64clk", ntk, 16);
    chk("first_q_rise", qr, 16);
    chk("q_leads_e", er1 - qr, 16);
    chk("e_period_normal", er2 - er1, 64);

    // Video round robin, both requesters active
    do_reset();
    vid_req = 2'b11;
    vid_addr = {16'h0600, 16'h0400};
    nacks = 0; addr_t = 0; prev_addr = ram_addr;
    for (int i = 0; i < 400 && nacks < 4; i++) begin
      step();
      if (ram_addr !== prev_addr && (ram_addr == 16'h0400 || ram_addr == 16'h0600)) begin
        addr_t = cyc; ack_addr = ram_addr;
      end
      prev_addr = ram_addr;
      if (vid_ack != '0) begin
        chk("ack_order", vid_ack, (nacks % 2 == 0) ? 2'b01 : 2'b10);
        chk("ack_latency", cyc - addr_t, 8);
        chk("ack_vid_data", vid_data, init_val(int'(ack_addr)));
        nacks++;
      end
    end
    chk("ack_count", nacks, 4);

    // CPU transaction table, one normal E cycle per entry
    vecs[0] = '{1'b1, 16'h1234, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 16'h1234, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 16'h00FF, 8'h3C, 8'h00};
    vecs[3] = '{1'b0, 16'h00FF, 8'h00, 8'h3C};
    vecs[4] = '{1'b0, 16'h1234, 8'h00, 8'hA5};
    vecs[5] = '{1'b1, 16'h1234, 8'h5A, 8'h00};
    vecs[6] = '{1'b0, 16'h1234, 8'h00, 8'h5A};
    vecs[7] = '{1'b0, 16'h0042, 8'h00, init_val(16'h0042)};
    vid_req = 2'b01;
    run_cycle();
    for (int v = 0; v < 8; v++) begin
      cpu_we = vecs[v].we; cpu_addr = vecs[v].addr; cpu_wdata = vecs[v].wdata;
      run_cycle();
      if (vecs[v].we) begin
        chk("wr_pulse_count", we_cnt, 1);
        chk("wr_pulse_phase", we_ph, 14);
      end else begin
        chk("rd_data", cpu_rdata, vecs[v].exp_rdata);
        chk("rd_no_write", we_cnt, 0);
      end
    end
    cpu_we = 1'b0;

    // Fast raised mid-cycle at ph 6
    vid_req = 2'b11;
    step_until_ph(6);
    fast = 1'b1;
    r1 = -1; r2 = -1; r3 = -1; ack_seen = 0; pe = e;
    for (int i = 1; i <= 200 && r3 < 0; i++) begin
      step();
      if (vid_ack != '0) ack_seen++;
      if (e && !pe) begin
        if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i; else r3 = i;
      end
      pe = e;
    end
    chk("fast_cur_cycle_len", r2 - r1, 48);
    chk("e_period_fast", r3 - r2, 32);
    chk("fast_no_ack", ack_seen, 0);
    fast = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (vid_ack != '0) found = 1'b1;
    end
    chk("video_restored", found, 1'b1);
    run_cycle();

    // Reset mid-cycle during a CPU write
    cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'h77;
    we_cnt = 0;
    for (int i = 0; i < 80 && mph != 9; i++) begin
      step();
      if (ram_we) we_cnt++;
    end
    reset = 1'b0;
    #1;
    check_all_zero("rstmid");
    model_reset();
    step();
    step();
    cpu_we = 1'b0;
    reset = 1'b1;
    qr = -1; pq = q;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (ram_we) we_cnt++;
      if (q && !pq && qr < 0) qr = i;
      pq = q;
    end
    chk("rstmid_no_we", we_cnt, 0);
    chk("rstmid_ph_restart", qr, 16);
    chk("rstmid_ram_kept", cpu_rdata, init_val(16'h2000));

    // Write at 9000: blocked when protected, written through otherwise
    cpu_we = 1'b1; cpu_addr = 16'h9000; cpu_wdata = 8'h55;
    run_cycle();
`ifdef MEM_SEQ_WRITE_PROTECT_EN
    chk("wp_ram_we", we_cnt, 0);
    chk("wp_hit_count", wp_cnt, 1);
`else
    chk("nowp_ram_we", we_cnt, 1);
    chk("nowp_hit_count", wp_cnt, 0);
`endif
    cpu_we = 1'b0;
    run_cycle();
`ifdef MEM_SEQ_WRITE_PROTECT_EN
    chk("wp_readback", cpu_rdata, init_val(16'h9000));
`else
    chk("nowp_readback", cpu_rdata, 8'h55);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        cpu_we    = $urandom_range(0, 1);
        cpu_addr  = ($urandom_range(0, 1) == 1) ? 16'(16'h7FF8 + $urandom_range(0, 15))
                                                : 16'($urandom);
        cpu_wdata = 8'($urandom);
        vid_req   = NV'($urandom);
        vid_addr  = {16'($urandom), 16'($urandom)};
      end
      if ($urandom_range(0, 199) == 0) fast = ~fast;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_slot_sequencer.md
Name: mem_slot_sequencer

Overview:
- Parametrised successor to the fixed clock-enable divider plus SAM time-slicing in the CoCo top level.
- Derives the pixel/peripheral tick from the fast system clock and generates the 6809E E/Q phases.
- Interleaves CPU and N video requesters onto one synchronous RAM port: round-robin video arbitration, normal/fast rate modes, deterministic capture points.
- Sits between the CPU, the VDG-style fetch units and the dpram.

Parameters:
- DIV, 4: clk cycles per tick; 57.272 MHz / 4 = 14.318 MHz.
- ADDR_W, 16: RAM address width.
- DATA_W, 8: RAM data width.
- NUM_VID, 2: number of video requesters; must be ≥ 1.
- WP_BASE, 16'h8000: first write-protected address; used only with the optional feature.

Ports:
- clk  in  1  system clock, 57.272 MHz.
- reset  in  1  asynchronous, active-low.
- tick  out  1  one-clk pulse every DIV clks.
- fast  in  1  0 = normal rate, 1 = CPU-only fast rate.
- e  out  1  CPU E phase.
- q  out  1  CPU Q phase.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_we  in  1  CPU write intent.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  latched read data.
- vid_req  in  NUM_VID  level requests.
- vid_addr  in  NUM_VID*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- vid_ack  out  NUM_VID  one-hot, one-clk pulse when vid_data is valid.
- vid_data  out  DATA_W  latched video data.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write strobe.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, one-clk read latency.
- wp_hit  out  1  protected-write pulse; driven only with the optional feature, else tied 0.

Behaviour:
- Reset: every output 0.
  - div counter = 0, phase ph = 0.
  - Round-robin pointer = NUM_VID-1, so requester 0 is served first.
  - mode = normal.
- tick is asserted while div_cnt == DIV-1; div_cnt wraps at DIV-1.
- ph advances only on tick.
- Normal mode (ph 0..15, wraps at 15):
  - q = 1 for ph 4..11; e = 1 for ph 8..15.
  - Video slot:
    - At the tick entering ph 2, the arbiter picks the first requester with vid_req set, searching upward from pointer+1 modulo NUM_VID.
    - ram_addr is loaded with that requester's address and the pointer is updated to the granted index.
    - With no request: no grant, pointer unchanged, ram_addr holds.
  - At the tick entering ph 4, a granted slot loads vid_data from ram_rdata and pulses vid_ack[g] for one clk.
  - CPU slot:
    - At the tick entering ph 10, ram_addr = cpu_addr and ram_wdata = cpu_wdata.
    - If cpu_we: ram_we is high for exactly the one clk coincident with the tick entering ph 15.
    - Otherwise, at the tick entering ph 15, cpu_rdata is loaded from ram_rdata.
- Fast mode (ph 0..7, wraps at 7):
  - q = 1 for ph 2..5; e = 1 for ph 4..7.
  - CPU address is loaded entering ph 2.
  - Write strobe and read capture both occur entering ph 7.
  - No video grants are made; vid_req stays pending and vid_ack stays 0.
- Mode switching:
  - fast is sampled only at the tick that wraps ph to 0.
  - A change mid-cycle takes effect on the next cycle, so an E period is never truncated.
- A requester that drops vid_req after being granted still receives its ack; data is never cancelled.
- Simultaneous requests from all requesters: each is served once per NUM_VID normal cycles.
- Reset asserted mid-cycle clears state immediately. After release, the first tick occurs DIV clks later.

Optional Feature:
- Macro: MEM_SEQ_WRITE_PROTECT_EN.
- Defined:
  - A CPU write with cpu_addr ≥ WP_BASE suppresses ram_we.
  - wp_hit pulses for one clk at the same point ram_we would have pulsed.
  - Reads are unaffected.
- Undefined:
  - All writes pass through.
  - wp_hit is tied 0.
  - WP_BASE is ignored.

Decomposition:
- Package mem_seq_pkg holds:
  - Phase constants: PH_VID_ADDR = 2, PH_VID_CAP = 4, PH_CPU_ADDR = 10, PH_CPU_END = 15, and the fast equivalents.
  - The E/Q high windows for both modes.
  - The mode enum {MODE_NORMAL, MODE_FAST}.
- Sub-module rr_arbiter: parametrised by NUM_VID; inputs req and pointer; outputs grant index and a valid flag.

Test Plan:
- Reset then run with DIV = 4: tick period is 4 clk. In normal mode the e period is 64 clk and q leads e by 16 clk.
- Normal mode, NUM_VID = 2, both requesting, addresses 16'h0400 and 16'h0600:
  - Grants alternate 0, 1, 0, 1.
  - Each ack arrives 8 clk after the address is driven.
  - vid_data matches RAM contents.
- CPU write of 8'hA5 to 16'h1234, then read back: ram_we is high for exactly 1 clk, entering ph 15, and cpu_rdata = 8'hA5.
- fast raised at ph 6:
  - Current cycle completes with 16 phases; next e period is 32 clk.
  - vid_ack stays 0 throughout.
  - Dropping fast restores video service at the next wrap.
- Reset pulsed at ph 9 during a CPU write: ram_we never pulses, all outputs read 0 immediately, and ph restarts at 0.
- With MEM_SEQ_WRITE_PROTECT_EN defined, write 8'h55 to 16'h9000: ram_we stays 0, wp_hit pulses once, and the RAM keeps its old value.
